// File: rtl/parking_gate_ctrl.sv
// Car-park entry gate: password check, timed gate opening, occupancy tracking, wrong-code lockout.
// Optional lockout (LOCKOUT state and timer) is built only when PARK_LOCKOUT_EN is defined.
module parking_gate_ctrl #(
    parameter int              PW_W        = 4,
    parameter logic [PW_W-1:0] PASSWORD    = 4'b1101,
    parameter int              CAPACITY    = 8,
    parameter int              MAX_TRIES   = 3,
    parameter int              GATE_CYCLES = 4,
    parameter int              LOCK_CYCLES = 16,
    localparam int             OCC_W       = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sensor1,
    input  logic             sensor2,
    input  logic [PW_W-1:0]  password,
    input  logic             pw_valid,
    output logic             success,
    output logic             failure,
    output logic             busy,
    output logic             gate_open,
    output logic             locked,
    output logic             full,
    output logic [OCC_W-1:0] occupancy
);

    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int TMR_MAX = (GATE_CYCLES > LOCK_CYCLES) ? GATE_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [OCC_W-1:0] CAP_C     = OCC_W'(CAPACITY);
    localparam logic [TRY_W-1:0] MAX_C     = TRY_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);
`ifdef PARK_LOCKOUT_EN
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_PW = 3'd1,
        CHECK   = 3'd2,
        GATE    = 3'd3
`ifdef PARK_LOCKOUT_EN
        , LOCKOUT = 3'd4
`endif
    } state_t;

    state_t            state_r, state_s;
    logic [TRY_W-1:0]  tries_r, tries_s;
    logic [TMR_W-1:0]  timer_r, timer_s;
    logic [PW_W-1:0]   pw_r, pw_s;
    logic [OCC_W-1:0]  occupancy_r, occ_s;
    logic              success_r, failure_r, busy_r, gate_open_r, full_r;
    logic              s2_prev_r, exit_pulse_r;
    logic              entry_s, fail_s, inc_s, exit_s;

    // Next-state, counters and captured code for the entry FSM
    always_comb begin
        state_s = state_r;
        tries_s = tries_r;
        timer_s = timer_r;
        pw_s    = pw_r;
        entry_s = 1'b0;
        fail_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable && sensor1 && !full_r) begin
                    state_s = WAIT_PW;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_PW: begin
                if (pw_valid) begin
                    pw_s    = password;
                    state_s = CHECK;
                end else if (!sensor1 || !enable) begin
                    state_s = IDLE;
                    tries_s = '0;
                end else begin
                    state_s = WAIT_PW;
                end
            end
            CHECK: begin
                if (pw_r == PASSWORD) begin
                    entry_s = 1'b1;
                    tries_s = '0;
                    timer_s = '0;
                    state_s = GATE;
                end else begin
                    fail_s = 1'b1;
`ifdef PARK_LOCKOUT_EN
                    tries_s = tries_r + 1'b1;
                    if ((tries_r + 1'b1) == MAX_C) begin
                        timer_s = '0;
                        state_s = LOCKOUT;
                    end else begin
                        state_s = WAIT_PW;
                    end
`else
                    // Without lockout the count only saturates; it never changes the flow
                    if (tries_r != MAX_C) begin
                        tries_s = tries_r + 1'b1;
                    end else begin
                        tries_s = tries_r;
                    end
                    state_s = WAIT_PW;
`endif
                end
            end
            GATE: begin
                if (timer_r == GATE_LAST) begin
                    state_s = IDLE;
                end else begin
                    timer_s = timer_r + 1'b1;
                end
            end
`ifdef PARK_LOCKOUT_EN
            LOCKOUT: begin
                if (timer_r == LOCK_LAST) begin
                    state_s = IDLE;
                    tries_s = '0;
                end else begin
                    timer_s = timer_r + 1'b1;
                end
            end
`endif
            default: begin
                state_s = IDLE;
                tries_s = '0;
                timer_s = '0;
            end
        endcase
    end

    // Occupancy update; an entry and an exit in the same cycle cancel out
    always_comb begin
        inc_s = entry_s && (occupancy_r != CAP_C);
        exit_s = exit_pulse_r && (occupancy_r != {OCC_W{1'b0}});
        if (inc_s && !exit_s) begin
            occ_s = occupancy_r + 1'b1;
        end else if (!inc_s && exit_s) begin
            occ_s = occupancy_r - 1'b1;
        end else begin
            occ_s = occupancy_r;
        end
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            tries_r      <= '0;
            timer_r      <= '0;
            pw_r         <= '0;
            occupancy_r  <= '0;
            success_r    <= 1'b0;
            failure_r    <= 1'b0;
            busy_r       <= 1'b0;
            gate_open_r  <= 1'b0;
            full_r       <= 1'b0;
            s2_prev_r    <= 1'b0;
            exit_pulse_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            tries_r      <= tries_s;
            timer_r      <= timer_s;
            pw_r         <= pw_s;
            occupancy_r  <= occ_s;
            success_r    <= entry_s;
            failure_r    <= fail_s;
            busy_r       <= (state_s != IDLE);
            gate_open_r  <= (state_s == GATE);
            full_r       <= (occ_s == CAP_C);
            s2_prev_r    <= sensor2;
            exit_pulse_r <= sensor2 & ~s2_prev_r;
        end
    end

`ifdef PARK_LOCKOUT_EN
    logic locked_r;

    // Lockout indicator follows the next state like the other outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked_r <= 1'b0;
        end else begin
            locked_r <= (state_s == LOCKOUT);
        end
    end

    assign locked = locked_r;
`else
    assign locked = 1'b0;
`endif

    assign success   = success_r;
    assign failure   = failure_r;
    assign busy      = busy_r;
    assign gate_open = gate_open_r;
    assign full      = full_r;
    assign occupancy = occupancy_r;

endmodule
